uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and hunts for a sync byte. It then collects a length-prefixed payload, verifies an 8-bit checksum, and streams only validated payload bytes to the command logic over a valid/ready interface. Malformed, timed-out or overrun frames are dropped and reported on a one-cycle error strobe.

## Interface
- SyncByte, 8'hAA: frame start marker.
- MaxLen, 16: maximum payload bytes; buffer depth; must be ≥1.
- TimeoutCycles, 50000: idle clocks allowed between bytes inside a frame (1 ms at 50 MHz).
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only in the cycle rx_data_ready=1.
- rx_data_ready  in  1  one-cycle byte strobe from the receiver.
- out_data  out  8  payload byte; reset 0.
- out_valid  out  1  out_data valid; reset 0.
- out_last  out  1  marks the final payload byte of a frame; reset 0.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- err_valid  out  1  one-cycle error strobe; reset 0.
- err_code  out  2  0=bad length, 1=checksum, 2=timeout, 3=overrun; held until the next error; reset 0.
- busy  out  1  high in any state other than IDLE; reset 0.

## Operation
- Checksum rule: (LEN + all payload bytes + CHK) mod 256 == 0. The frame is SYNC, LEN, LEN payload bytes, CHK.
- IDLE: a byte equal to SyncByte moves to LEN. Any other byte is ignored silently.
- LEN: LEN==0 or LEN>MaxLen gives err code 0 and a return to IDLE. The offending byte is not rechecked as sync. Otherwise store LEN, seed the sum with LEN, clear the index, and go to PAYLOAD.
- PAYLOAD: write the byte to buffer[index], add it to the sum, and increment the index. After the LEN-th byte, go to CHK.
- CHK: if sum+byte≠0 mod 256, raise err code 1 and go to IDLE. Otherwise go to DRAIN with the read pointer at 0.
- DRAIN: present buffer[rd]. out_last=1 when rd==LEN-1. Advance on each handshake. After the last handshake, go to IDLE.
- In DRAIN, an incoming byte is dropped with err code 3. Draining continues unaffected.
- Timeout counter:
  - Cleared on every accepted byte and on entry to LEN.
  - Counts in LEN, PAYLOAD and CHK.
  - On reaching TimeoutCycles-1 with no byte that cycle: err code 2, go to IDLE.
  - Not active in IDLE or DRAIN.
- Sum and index widths: 8-bit modulo sum. Index and LEN are clog2(MaxLen+1) bits; no wrap is possible because LEN≤MaxLen.
- Reset mid-frame or mid-drain: all state returns to IDLE, outputs go to reset values, and a partially drained frame is discarded.

## Timing
- A byte is consumed at the posedge where rx_data_ready=1. State and errors update at that edge, so they are visible the cycle after the strobe.
- err_valid is high for exactly one cycle, the cycle after the offending byte or timeout expiry.
- CHK accepted at edge t: out_valid=1 with byte 0 from cycle t+1. Zero-bubble streaming applies when out_ready is held high, so a LEN-byte frame drains in LEN cycles.
- out_data and out_last are stable while out_valid && !out_ready.
- out_valid drops, and busy drops, in the cycle after the last handshake. A SYNC strobe in that same cycle is accepted.
- A byte strobe in the cycle the timeout would expire takes priority: the byte is processed and there is no error.

## Structure
- Shared package or header uart_frame_pkg holds:
  - the state encoding (IDLE, LEN, PAYLOAD, CHK, DRAIN);
  - the err_code constants;
  - the SyncByte default.
- Sub-module uart_frame_buf: MaxLen×8 register file with one synchronous write port and one combinational read port. The parser owns the FSM, sum, counters and handshake.

## Test plan
- Good frame: AA 03 11 22 33 97 with out_ready=1 -> beats 11, 22, 33, out_last only on 33, no err_valid.
- Backpressure: same frame, out_ready toggled 0/1 each cycle -> beats unchanged, each held stable while stalled.
- Bad checksum: AA 02 01 02 00 -> err_code 1 pulse, no out_valid; next good frame is parsed normally.
- Bad length: AA 00, then AA 11 (MaxLen=16) -> two err_code 0 pulses. Preceding noise bytes 55 AA followed by a good frame -> parsed correctly.
- Timeout: AA 03 11, then silence for TimeoutCycles -> err_code 2 exactly TimeoutCycles cycles after byte 11, busy drops.
- Overrun and reset: byte arrives during drain with out_ready=0 -> err_code 3, drain intact. Separately, rst_n asserted mid-PAYLOAD -> all outputs 0 and next frame OK.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// State encoding, error codes and the default sync marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_e;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CHKSUM  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;

    function automatic int widthOf(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port,
// one combinational read port.
module uart_frame_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Sync hunt, length-prefixed payload capture, checksum check
// and valid/ready streaming of validated payload bytes.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SyncByte      = SYNC_BYTE,
    parameter int         MaxLen        = 16,
    parameter int         TimeoutCycles = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int LW = $clog2(MaxLen + 1);
    localparam int AW = widthOf(MaxLen);
    localparam int TW = widthOf(TimeoutCycles);
    localparam logic [7:0]    MaxLenB = 8'(MaxLen);
    localparam logic [TW-1:0] TmoLast = TW'(TimeoutCycles - 1);

    state_e        state, stateD;
    logic [LW-1:0] lenQ, lenD;
    logic [LW-1:0] idx, idxD;
    logic [LW-1:0] rdPtr, rdD;
    logic [7:0]    sum, sumD;
    logic [TW-1:0] tmo, tmoD;
    logic          errValid, errD;
    logic [1:0]    errCode, codeD;
    logic          we;
    logic [7:0]    rdByte;
    logic [7:0]    sumChk;
    logic [LW-1:0] lenM1;
    logic          lenBad;
    logic          tmoHit;

    assign lenM1  = lenQ - LW'(1);
    assign sumChk = sum + rx_data;
    assign lenBad = (rx_data == 8'd0) || (rx_data > MaxLenB);
    // A byte in the expiry cycle wins over the timeout.
    assign tmoHit = (tmo == TmoLast) && !rx_data_ready;

    uart_frame_buf #(
        .AW(AW)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .waddr(idx[AW-1:0]),
        .wdata(rx_data),
        .raddr(rdPtr[AW-1:0]),
        .rdata(rdByte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lenQ     <= '0;
            idx      <= '0;
            rdPtr    <= '0;
            sum      <= '0;
            tmo      <= '0;
            errValid <= 1'b0;
            errCode  <= ERR_LEN;
        end else begin
            state    <= stateD;
            lenQ     <= lenD;
            idx      <= idxD;
            rdPtr    <= rdD;
            sum      <= sumD;
            tmo      <= tmoD;
            errValid <= errD;
            errCode  <= codeD;
        end
    end

    always_comb begin
        stateD = state;
        lenD   = lenQ;
        idxD   = idx;
        rdD    = rdPtr;
        sumD   = sum;
        tmoD   = tmo;
        errD   = 1'b0;
        codeD  = errCode;
        we     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                tmoD = '0;
                if (rx_data_ready && rx_data == SyncByte) begin
                    stateD = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_data_ready) begin
                    tmoD = '0;
                    if (lenBad) begin
                        errD   = 1'b1;
                        codeD  = ERR_LEN;
                        stateD = ST_IDLE;
                    end else begin
                        lenD   = rx_data[LW-1:0];
                        sumD   = rx_data;
                        idxD   = '0;
                        stateD = ST_PAYLOAD;
                    end
                end else if (tmoHit) begin
                    errD   = 1'b1;
                    codeD  = ERR_TIMEOUT;
                    stateD = ST_IDLE;
                end else begin
                    tmoD = tmo + 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (rx_data_ready) begin
                    tmoD = '0;
                    we   = 1'b1;
                    sumD = sumChk;
                    idxD = idx + 1'b1;
                    if (idx == lenM1) begin
                        stateD = ST_CHK;
                    end
                end else if (tmoHit) begin
                    errD   = 1'b1;
                    codeD  = ERR_TIMEOUT;
                    stateD = ST_IDLE;
                end else begin
                    tmoD = tmo + 1'b1;
                end
            end
            ST_CHK: begin
                if (rx_data_ready) begin
                    tmoD = '0;
                    if (sumChk != 8'd0) begin
                        errD   = 1'b1;
                        codeD  = ERR_CHKSUM;
                        stateD = ST_IDLE;
                    end else begin
                        rdD    = '0;
                        stateD = ST_DRAIN;
                    end
                end else if (tmoHit) begin
                    errD   = 1'b1;
                    codeD  = ERR_TIMEOUT;
                    stateD = ST_IDLE;
                end else begin
                    tmoD = tmo + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Bytes cannot be buffered while draining.
                if (rx_data_ready) begin
                    errD  = 1'b1;
                    codeD = ERR_OVERRUN;
                end
                if (out_ready) begin
                    if (rdPtr == lenM1) begin
                        stateD = ST_IDLE;
                    end else begin
                        rdD = rdPtr + 1'b1;
                    end
                end
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid && (rdPtr == lenM1);
    assign out_data  = out_valid ? rdByte : 8'd0;
    assign busy      = (state != ST_IDLE);
    assign err_valid = errValid;
    assign err_code  = errCode;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: frame vector table
// plus hand-written timeout, overrun and reset sequences.
module tb_uart_frame_parser;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_data_ready = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       err_valid;
    logic [1:0] err_code;
    logic       busy;

    uart_frame_parser #(
        .SyncByte     (8'hAA),
        .MaxLen       (16),
        .TimeoutCycles(T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b [20];
        int         n;
        int         pStart;
        int         pLen;
        int         err;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } beat_t;

    vec_t  tv [8];
    beat_t expQ [$];
    int    expErr [$];
    beat_t eb;
    int    ee;
    int    nChecks = 0;
    int    nPass = 0;
    int    readyMode = 0;
    logic       stall = 1'b0;
    logic [7:0] stallD = 8'd0;
    logic       stallL = 1'b0;
    logic       prevErr = 1'b0;

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        nChecks++;
        if (ok) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall   = 1'b0;
            prevErr = 1'b0;
        end else begin
            if (stall)
                check(out_valid && out_data == stallD && out_last == stallL,
                      "stall hold", int'({out_valid, out_last, out_data}),
                      int'({1'b1, stallL, stallD}));
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    check(1'b0, "unexpected beat", int'(out_data), 0);
                end else begin
                    eb = expQ.pop_front();
                    check(out_data == eb.d && out_last == eb.last, "beat",
                          int'({out_last, out_data}), int'({eb.last, eb.d}));
                end
            end
            stall  = out_valid && !out_ready;
            stallD = out_data;
            stallL = out_last;
            if (prevErr)
                check(!err_valid, "err pulse width", int'(err_valid), 0);
            if (err_valid) begin
                if (expErr.size() == 0) begin
                    check(1'b0, "unexpected err", int'(err_code), 0);
                end else begin
                    ee = expErr.pop_front();
                    check(int'(err_code) == ee, "err code", int'(err_code), ee);
                end
            end
            prevErr = err_valid;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic pushBeats(input int i);
        for (int k = 0; k < tv[i].pLen; k++)
            expQ.push_back('{tv[i].b[tv[i].pStart + k], k == tv[i].pLen - 1});
    endtask

    task automatic sendVec(input int i);
        for (int k = 0; k < tv[i].n; k++) sendByte(tv[i].b[k]);
    endtask

    task automatic waitDone(input string name);
        int c = 0;
        while ((busy || expQ.size() != 0 || expErr.size() != 0) && c < 400) begin
            @(negedge clk);
            c++;
        end
        check(c < 400, name, c, 400);
    endtask

    task automatic runVec(input int i);
        if (tv[i].err >= 0) expErr.push_back(tv[i].err);
        pushBeats(i);
        sendVec(i);
        waitDone($sformatf("vec%0d done", i));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        tv[0].b = '{0: 8'hAA, 1: 8'h03, 2: 8'h11, 3: 8'h22, 4: 8'h33,
                    5: 8'h97, default: 8'h00};
        tv[0].n = 6; tv[0].pStart = 2; tv[0].pLen = 3; tv[0].err = -1;
        tv[1].b = '{0: 8'hAA, 1: 8'h02, 2: 8'h01, 3: 8'h02, 4: 8'h00,
                    default: 8'h00};
        tv[1].n = 5; tv[1].pStart = 0; tv[1].pLen = 0; tv[1].err = 1;
        tv[2].b = '{0: 8'hAA, 1: 8'h00, default: 8'h00};
        tv[2].n = 2; tv[2].pStart = 0; tv[2].pLen = 0; tv[2].err = 0;
        tv[3].b = '{0: 8'hAA, 1: 8'h11, default: 8'h00};
        tv[3].n = 2; tv[3].pStart = 0; tv[3].pLen = 0; tv[3].err = 0;
        tv[4].b = '{0: 8'h55, 1: 8'hAA, 2: 8'h01, 3: 8'h5A, 4: 8'hA5,
                    default: 8'h00};
        tv[4].n = 5; tv[4].pStart = 3; tv[4].pLen = 1; tv[4].err = -1;
        tv[5].b = '{0: 8'hAA, 1: 8'h10, 18: 8'h78, default: 8'h00};
        for (int k = 0; k < 16; k++) tv[5].b[2 + k] = 8'(k);
        tv[5].n = 19; tv[5].pStart = 2; tv[5].pLen = 16; tv[5].err = -1;
        tv[6].b = '{0: 8'hAA, 1: 8'h01, 2: 8'hFF, 3: 8'h00, default: 8'h00};
        tv[6].n = 4; tv[6].pStart = 2; tv[6].pLen = 1; tv[6].err = -1;
        tv[7].b = '{0: 8'hAA, 1: 8'hAA, 2: 8'h01, 3: 8'h5A, 4: 8'hA5,
                    default: 8'h00};
        tv[7].n = 5; tv[7].pStart = 0; tv[7].pLen = 0; tv[7].err = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!out_valid, "reset out_valid", int'(out_valid), 0);
        check(!out_last, "reset out_last", int'(out_last), 0);
        check(out_data == 8'd0, "reset out_data", int'(out_data), 0);
        check(!err_valid, "reset err_valid", int'(err_valid), 0);
        check(err_code == 2'd0, "reset err_code", int'(err_code), 0);
        check(!busy, "reset busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        readyMode = 0;
        for (int i = 0; i < 8; i++) runVec(i);

        readyMode = 1;
        runVec(0);
        runVec(5);
        readyMode = 0;

        // SYNC in the cycle right after the last handshake.
        pushBeats(0);
        pushBeats(6);
        sendVec(0);
        c = 0;
        while (!(out_valid && out_ready && out_last) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check(c < 100, "b2b last beat", c, 100);
        sendVec(6);
        waitDone("b2b done");

        // Byte arriving in the timeout expiry cycle is processed.
        expQ.push_back('{8'h5A, 1'b1});
        sendByte(8'hAA);
        sendByte(8'h01);
        repeat (T - 2) @(posedge clk);
        sendByte(8'h5A);
        sendByte(8'hA5);
        waitDone("tmo priority done");

        expErr.push_back(2);
        sendByte(8'hAA);
        sendByte(8'h03);
        sendByte(8'h11);
        c = 0;
        while (!err_valid && c < T + 20) begin
            @(negedge clk);
            c++;
        end
        check(c - 1 == T, "timeout latency", c - 1, T);
        check(!busy, "timeout busy", int'(busy), 0);
        waitDone("timeout done");

        readyMode = 2;
        expQ.push_back('{8'h10, 1'b0});
        expQ.push_back('{8'h20, 1'b1});
        sendByte(8'hAA);
        sendByte(8'h02);
        sendByte(8'h10);
        sendByte(8'h20);
        sendByte(8'hCE);
        expErr.push_back(3);
        sendByte(8'h77);
        repeat (2) @(negedge clk);
        check(expErr.size() == 0, "overrun err seen", expErr.size(), 0);
        check(out_valid && out_data == 8'h10 && !out_last, "drain intact",
              int'({out_valid, out_last, out_data}), int'({1'b1, 1'b0, 8'h10}));
        readyMode = 0;
        waitDone("overrun done");

        sendByte(8'hAA);
        sendByte(8'h04);
        sendByte(8'h01);
        sendByte(8'h02);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check({out_valid, out_last, out_data, err_valid, err_code, busy} == 13'd0,
              "mid-frame reset",
              int'({out_valid, out_last, out_data, err_valid, err_code, busy}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runVec(0);

        repeat (5) @(negedge clk);
        check(expQ.size() == 0, "beat queue empty", expQ.size(), 0);
        check(expErr.size() == 0, "err queue empty", expErr.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
